// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit.
// MAU_MISALIGN_CHECK_EN selects alignment error reporting in the top level.
package mau_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    function automatic logic is_sub_word(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane extraction/extension for loads and lane merge for stores.
// Size code 3 falls through to whole-word handling.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [BYTE_W-1:0] byte_d;
    logic [HALF_W-1:0] half_d;

    assign byte_d = word_i[{addr_i, 3'b000} +: BYTE_W];
    assign half_d = word_i[{addr_i[1], 4'b0000} +: HALF_W];

    always_comb begin
        load_o  = word_i;
        store_o = wdata_i;
        unique case (size_i)
            SZ_BYTE: begin
                load_o  = unsigned_i ? {24'd0, byte_d}
                                     : {{24{byte_d[BYTE_W-1]}}, byte_d};
                store_o = word_i;
                store_o[{addr_i, 3'b000} +: BYTE_W] = wdata_i[BYTE_W-1:0];
            end
            SZ_HALF: begin
                load_o  = unsigned_i ? {16'd0, half_d}
                                     : {{16{half_d[HALF_W-1]}}, half_d};
                store_o = word_i;
                store_o[{addr_i[1], 4'b0000} +: HALF_W] = wdata_i[HALF_W-1:0];
            end
            default: begin
                load_o  = word_i;
                store_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit turning sub-word accesses into word RAM reads/writes.
// Define MAU_MISALIGN_CHECK_EN to report misaligned/reserved-size accesses.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata
);

    state_e            state_q;
    logic [1:0]        addr_lo_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic [31:0]       wdata_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;
    logic              ram_we_q;

    logic              misalign_d;
    logic [ADDR_W-1:0] word_addr_d;
    logic [31:0]       ld_data_d;
    logic [31:0]       wr_word_d;

`ifdef MAU_MISALIGN_CHECK_EN
    assign misalign_d = (req_size == 2'd3)
                     || (req_size == SZ_HALF && req_addr[0])
                     || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
    assign misalign_d = 1'b0;
`endif

    assign word_addr_d = ADDR_W'({req_addr[31:2], 2'b00});

    mau_lane_align u_align (
        .word_i     (ram_rdata),
        .addr_i     (addr_lo_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .load_o     (ld_data_d),
        .store_o    (wr_word_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_lo_q    <= '0;
            size_q       <= '0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_we_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_lo_q   <= req_addr[1:0];
                        size_q      <= req_size;
                        we_q        <= req_we;
                        uns_q       <= req_unsigned;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (misalign_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (!req_we || is_sub_word(req_size)) begin
                            state_q    <= READ;
                            ram_addr_q <= word_addr_d;
                        end else begin
                            state_q     <= WRITE;
                            ram_addr_q  <= word_addr_d;
                            ram_wdata_q <= req_wdata;
                            ram_we_q    <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (we_q) begin
                        state_q     <= WRITE;
                        ram_wdata_q <= wr_word_d;
                        ram_we_q    <= 1'b1;
                    end else begin
                        state_q      <= RESP;
                        ram_addr_q   <= '0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= ld_data_d;
                    end
                end
                WRITE: begin
                    state_q      <= RESP;
                    ram_we_q     <= 1'b0;
                    ram_addr_q   <= '0;
                    ram_wdata_q  <= '0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A store caught by reset must not reach the RAM on that edge.
    assign ram_we     = ram_we_q & rst_n;
    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a byte-array reference memory.
// Honours MAU_MISALIGN_CHECK_EN when computing expected responses.
module tb_mem_access_unit;
    import mau_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .ram_rdata    (ram_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
        int          widx;
        logic [31:0] word;
        int          cyc0;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    logic [31:0] ram [0:63];
    logic [7:0]  refb [0:255];
    logic [31:0] exp_waddr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    assign ram_rdata = ram[ram_addr[7:2]];

    function automatic logic [31:0] init_word(input int i);
        case (i)
            1:       return 32'h8034_12F0;
            2:       return 32'h1122_3344;
            default: return (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // RAM model: combinational read, synchronous write
    initial begin
        for (int i = 0; i < 64; i++) ram[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (ram_we) ram[ram_addr[7:2]] <= ram_wdata;
        end
    end

    // Monitor: pops the scoreboard on each new response
    initial begin
        logic        pv;
        logic [31:0] prd;
        logic        perr;
        int          wes;
        exp_t        e;
        pv = 1'b0; prd = '0; perr = 1'b0; wes = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wes = 0;
                pv  = 1'b0;
            end else begin
                if (ram_we) begin
                    wes++;
                    chk("ram_addr", ram_addr, exp_waddr);
                end
                if (resp_valid) begin
                    chk("req_ready_busy", 32'(req_ready), 32'd0);
                    if (!pv) begin
                        if (sb.size() == 0) begin
                            total++;
                            $display("FAIL unexpected_resp: got rdata %h", resp_rdata);
                        end else begin
                            e = sb.pop_front();
                            chk("resp_rdata", resp_rdata, e.rdata);
                            chk("resp_err", 32'(resp_err), 32'(e.err));
                            chk("latency", 32'(cyc - e.cyc0), 32'(e.lat));
                            chk("we_cycles", 32'(wes), 32'(e.wes));
                            chk("ram_word", ram[e.widx], e.word);
                        end
                        wes = 0;
                    end else begin
                        chk("hold_rdata", resp_rdata, prd);
                        chk("hold_err", 32'(resp_err), 32'(perr));
                    end
                    prd  = resp_rdata;
                    perr = resp_err;
                end
                pv = resp_valid;
            end
        end
    end

    task automatic wait_ready(output logic ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        if (!ok) begin
            total++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int hold);
        exp_t        e;
        int          n, base, cnt, h;
        logic        ok, done;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = int'(addr[7:0]) / n * n;
        wait_ready(ok);
        if (!ok) return;
`ifdef MAU_MISALIGN_CHECK_EN
        e.err = (sz == 2'd3) || (int'(addr[7:0]) % n != 0);
`else
        e.err = 1'b0;
`endif
        e.rdata = '0;
        e.wes   = 0;
        e.widx  = base / 4;
        if (e.err) begin
            e.lat = 1;
        end else if (!we) begin
            v = '0;
            for (int k = 0; k < n; k++) v |= 32'(refb[base+k]) << (8*k);
            if (n < 4 && !uns && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
            e.rdata = v;
            e.lat   = 2;
        end else begin
            for (int k = 0; k < n; k++) refb[base+k] = 8'(wd >> (8*k));
            e.wes = 1;
            e.lat = (n == 4) ? 2 : 3;
        end
        e.word = ref_word(e.widx);
        e.cyc0 = cyc;
        exp_waddr    = {addr[31:2], 2'b00};
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_we    = 1'(~we);
        h = hold;
        cnt = 0;
        done = 1'b0;
        while (!done && cnt < 60) begin
            @(negedge clk);
            cnt++;
            if (resp_valid) begin
                req_valid = 1'b0;
                if (h > 0) begin
                    resp_ready = 1'b0;
                    h--;
                end else begin
                    resp_ready = 1'($urandom_range(0, 1));
                end
                if (resp_ready) begin
                    @(posedge clk);
                    #1;
                    resp_ready = 1'b0;
                    done = 1'b1;
                end
            end else begin
                req_valid  = 1'($urandom_range(0, 1));
                resp_ready = 1'($urandom_range(0, 1));
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        if (!done) begin
            total++;
            $display("FAIL resp_timeout: got no handshake expected one");
        end
    endtask

    task automatic reset_during_store();
        logic ok;
        int   n;
        wait_ready(ok);
        if (!ok) return;
        exp_waddr    = 32'h0000_0008;
        req_we       = 1'b1;
        req_size     = SZ_BYTE;
        req_unsigned = 1'b0;
        req_addr     = 32'h0000_0009;
        req_wdata    = 32'h0000_00CD;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ram_we && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("write_reached", 32'(ram_we), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_word_kept", ram[2], ref_word(2));
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] sz;
        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 4; k++) refb[4*i+k] = 8'(init_word(i) >> (8*k));
        end
        repeat (3) @(negedge clk);
        chk("rst_req_ready0", 32'(req_ready), 32'd1);
        chk("rst_resp_valid0", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata0", resp_rdata, 32'd0);
        chk("rst_resp_err0", 32'(resp_err), 32'd0);
        chk("rst_ram_we0", 32'(ram_we), 32'd0);
        chk("rst_ram_addr0", ram_addr, 32'd0);
        chk("rst_ram_wdata0", ram_wdata, 32'd0);
        rst_n = 1'b1;

        issue(1'b0, SZ_BYTE, 1'b0, 32'h5, 32'h0, 0);
        issue(1'b0, SZ_HALF, 1'b0, 32'h6, 32'h0, 0);
        issue(1'b0, SZ_HALF, 1'b1, 32'h6, 32'h0, 0);
        issue(1'b1, SZ_BYTE, 1'b0, 32'hA, 32'hAB, 0);
        issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
        issue(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h5566, 0);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 0);
        issue(1'b0, SZ_WORD, 1'b0, 32'h3, 32'h0, 0);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 4);
        issue(1'b0, 2'd3, 1'b0, 32'h21, 32'h0, 1);
        reset_during_store();
        issue(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 0);

        for (int t = 0; t < 200; t++) begin
            sz = 2'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            $display("FAIL sb_leftover: got %0d expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit between the CPU MEM stage and the word-wide data `ram`.
- Converts byte/halfword/word load and store requests into whole-word `ram` reads and writes.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Valid/ready handshake upstream and downstream; one access in flight at a time.

Parameters:
- ADDR_W, 32, width of byte address presented to `ram`.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1=store, 0=load
- req_size  in  2  access size code (mau_pkg: SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2; 3 reserved, treated as misaligned)
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misaligned/reserved-size access
- ram_addr  out  ADDR_W  word-aligned address (bits [1:0]=0)
- ram_wdata  out  32  word to write
- ram_we  out  1  write strobe, one cycle
- ram_rdata  in  32  combinational read data from `ram`

Behaviour:
- Byte order is little-endian: byte k occupies bits [8k+7:8k].
- States: IDLE, READ, WRITE, RESP.
- Reset (rst_n=0 at posedge):
  - State goes to IDLE; abandons any in-flight access.
  - Outputs go to req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - A store in WRITE at the reset edge is not committed (ram_we is forced 0 during reset).
- Accept: req_valid & req_ready at a posedge latches addr, size, we, unsigned, wdata.
- Misalignment:
  - HALF with addr[0]=1, WORD with addr[1:0]!=0, or size=3 is misaligned.
  - Misaligned goes IDLE->RESP with resp_err=1 and resp_rdata=0; no `ram` access.
- Load: IDLE->READ->RESP.
  - In READ, ram_addr = {addr[31:2],2'b00}.
  - At the READ edge, the selected lane is captured and extended into resp_rdata.
- Word store: IDLE->WRITE->RESP.
  - In WRITE, ram_we=1 and ram_wdata=wdata.
- Sub-word store: IDLE->READ->WRITE->RESP.
  - READ captures the old word.
  - WRITE drives the old word with the addressed byte/half replaced by wdata[7:0]/[15:0].
  - Other bytes are unchanged.
- RESP: resp_valid=1, held stable until resp_ready; then ->IDLE.
  - Back-to-back: the next request is accepted the cycle after RESP exits; no bypass from RESP to READ.
- Latency from accept edge to resp_valid:
  - misaligned: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- ram_we is high only in WRITE; ram_addr holds the latched word address in READ/WRITE, 0 otherwise.
- Request inputs are ignored outside IDLE.
- resp_ready while resp_valid=0 is ignored.

Optional Feature:
- Macro MAU_MISALIGN_CHECK_EN.
- Defined: misalignment detection exactly as above.
- Undefined:
  - resp_err tied 0.
  - Low address bits below the access size are ignored: HALF uses addr[1], WORD uses neither.
  - Every access proceeds to `ram`; size=3 is treated as WORD.

Decomposition:
- mau_pkg holds:
  - size_e enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state_e enum (IDLE, READ, WRITE, RESP)
  - BYTE_W=8 and HALF_W=16 constants
- One combinational sub-module, mau_lane_align, takes (word, addr[1:0], size, unsigned, wdata).
  - Outputs the extended load value and the merged store word.
  - Shared by the READ capture and WRITE paths.

Test Plan:
- Preload ram[1]=32'h8034_12F0; LB addr=0x5, signed -> resp_rdata=32'h0000_0012, resp_err=0, resp_valid exactly 2 cycles after accept.
- Same word; LH addr=0x6, signed -> 32'hFFFF_8034; LHU addr=0x6 -> 32'h0000_8034.
- ram[2]=32'h1122_3344; SB addr=0xA wdata=0xAB -> ram[2]=32'h11AB_3344, ram_we high for exactly one cycle, resp 3 cycles after accept.
- SW addr=0x10 wdata=32'hDEAD_BEEF -> ram[4]=32'hDEAD_BEEF, no READ cycle, resp 2 cycles after accept; SH addr=0x12 wdata=0x5566 then LW addr=0x10 -> 32'h5566_BEEF.
- With MAU_MISALIGN_CHECK_EN: LW addr=0x3 -> resp_err=1, resp_rdata=0, ram_we never asserted, resp 1 cycle after accept. Without the macro: same request -> resp_err=0, resp_rdata=ram[0].
- Backpressure and reset:
  - Hold resp_ready=0 for 4 cycles -> resp_valid and data stable, req_ready=0 throughout.
  - Assert rst_n=0 during WRITE of an SB -> target word unchanged, req_ready=1 and resp_valid=0 after the edge.
